// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory loader
// Packs little-endian bytes into 32-bit words and writes them from address 0 while holding the CPU.
module imem_loader #(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [6:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  localparam int GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [6:0]        cnt_in;

  assign cnt_in = (word_count > DEPTH_C) ? DEPTH_C : word_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_addr_q <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      checksum_q  <= '0;
      gap_q       <= '0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_addr_q <= word_addr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      checksum_q  <= checksum_d;
      gap_q       <= gap_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_addr_d = word_addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    checksum_d  = checksum_q;
    gap_d       = gap_q;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          cnt_d       = cnt_in;
          word_addr_d = '0;
          byte_idx_d  = '0;
          checksum_d  = '0;
          gap_d       = '0;
          state_d     = (cnt_in == 7'd0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          word_d[8*byte_idx_q +: 8] = byte_data;
          checksum_d = checksum_q + byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          gap_d      = '0;
          // Capture the write port now so it can hold its value outside WRITE.
          if (byte_idx_q == 2'd3) begin
            im_addr_d  = word_addr_q;
            im_wdata_d = {byte_data, word_q[23:0]};
            state_d    = WRITE;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = ERROR;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      WRITE: begin
        word_addr_d = word_addr_q + ADDR_W'(1);
        byte_idx_d  = '0;
        state_d     = ({1'b0, word_addr_q} == cnt_q - 7'd1) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
    // Abort discards the partial word and leaves the last write port values and checksum untouched.
    if (abort) begin
      state_d    = IDLE;
      byte_idx_d = '0;
      gap_d      = '0;
      checksum_d = checksum_q;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
    end
  end

  assign im_we      = (state_q == WRITE) && !abort;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign byte_ready = (state_q == RECV);
  assign cpu_hold   = (state_q == RECV) || (state_q == WRITE) || (state_q == ERROR);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);
  assign checksum   = checksum_q;

endmodule
